// File: rtl/spi_command_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | spi_command_decoder: SPI byte-stream opcode/address/value frame decoder     |
// | with tear-free STREAM/TRANSFER read-back. Option: SPI_CMD_TIMEOUT_EN         |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module spi_command_decoder #(
    parameter int ADDRESS_WIDTH  = 24,
    parameter int VALUE_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     spi_rx_valid_i,
    input  logic [7:0]               spi_rx_byte_i,
    input  logic [VALUE_WIDTH-1:0]   result_i,
    input  logic [VALUE_WIDTH-1:0]   stream_i,
    output logic [7:0]               instruction_o,
    output logic [ADDRESS_WIDTH-1:0] address_o,
    output logic [VALUE_WIDTH-1:0]   value_o,
    output logic                     cmd_valid_o,
    output logic                     err_o,
    output logic [7:0]               spi_tx_byte_o
);

    localparam int AB    = ADDRESS_WIDTH / 8;
    localparam int VB    = VALUE_WIDTH / 8;
    localparam int SHW   = ADDRESS_WIDTH + VALUE_WIDTH;
    localparam int CNT_W = $clog2(AB + VB + 1);
    localparam int PTR_W = (VB > 1) ? $clog2(VB) : 1;

    localparam logic [7:0] OP_WRITE     = 8'h01;
    localparam logic [7:0] OP_READ      = 8'h02;
    localparam logic [7:0] OP_STREAM    = 8'h03;
    localparam logic [7:0] OP_BIND_INT  = 8'h04;
    localparam logic [7:0] OP_BIND_RD   = 8'h05;
    localparam logic [7:0] OP_BIND_WR   = 8'h06;
    localparam logic [7:0] OP_TRANSFER  = 8'h07;
    localparam logic [7:0] OP_REPEAT    = 8'h08;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                     state, state_nxt;
    logic [CNT_W-1:0]           cnt, cnt_nxt;
    logic [SHW-1:0]             shift, shift_nxt, shifted;
    logic [7:0]                 opcode, opcode_nxt;
    logic [VB-1:0][7:0]         stream_snap, stream_snap_nxt;
    logic [VB-1:0][7:0]         xfer_snap, xfer_snap_nxt;
    logic [PTR_W-1:0]           ptr, ptr_nxt;
    logic [PTR_W-1:0]           stream_idx, xfer_idx;
    logic [7:0]                 instr_nxt, tx_nxt;
    logic [ADDRESS_WIDTH-1:0]   addr_nxt;
    logic [VALUE_WIDTH-1:0]     value_nxt;
    logic                       cmd_valid_nxt, err_nxt;
    logic                       timeout;

`ifdef SPI_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] idle_cnt;

    // Counts only silent cycles inside a partial frame; any byte restarts it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_cnt <= '0;
        end else if (state != COLLECT || spi_rx_valid_i || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TMO_W'(1);
        end
    end

    assign timeout = (state == COLLECT) && !spi_rx_valid_i
                     && (idle_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Byte k of a STREAM value frame sends snapshot byte VB-1-k, i.e. cnt-2.
    assign stream_idx = PTR_W'(cnt - CNT_W'(2));
    assign xfer_idx   = PTR_W'(VB - 1) - ptr;
    assign shifted    = {shift[SHW-9:0], spi_rx_byte_i};

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        shift_nxt       = shift;
        opcode_nxt      = opcode;
        stream_snap_nxt = stream_snap;
        xfer_snap_nxt   = xfer_snap;
        ptr_nxt         = ptr;
        instr_nxt       = instruction_o;
        addr_nxt        = address_o;
        value_nxt       = value_o;
        tx_nxt          = spi_tx_byte_o;
        cmd_valid_nxt   = 1'b0;
        err_nxt         = 1'b0;

        case (state)
            IDLE: begin
                if (spi_rx_valid_i) begin
                    case (spi_rx_byte_i)
                        8'h00: begin
                        end
                        OP_WRITE: begin
                            opcode_nxt = spi_rx_byte_i;
                            shift_nxt  = '0;
                            cnt_nxt    = CNT_W'(AB + VB);
                            state_nxt  = COLLECT;
                        end
                        OP_READ, OP_BIND_INT, OP_BIND_RD, OP_BIND_WR: begin
                            opcode_nxt = spi_rx_byte_i;
                            shift_nxt  = '0;
                            cnt_nxt    = CNT_W'(AB);
                            state_nxt  = COLLECT;
                        end
                        OP_STREAM: begin
                            opcode_nxt      = spi_rx_byte_i;
                            shift_nxt       = '0;
                            cnt_nxt         = CNT_W'(VB);
                            state_nxt       = COLLECT;
                            stream_snap_nxt = stream_i;
                            tx_nxt          = stream_i[VALUE_WIDTH-1 -: 8];
                        end
                        OP_TRANSFER: begin
                            instr_nxt     = OP_TRANSFER;
                            addr_nxt      = '0;
                            value_nxt     = '0;
                            cmd_valid_nxt = 1'b1;
                            if (ptr == '0) begin
                                xfer_snap_nxt = result_i;
                                tx_nxt        = result_i[VALUE_WIDTH-1 -: 8];
                            end else begin
                                tx_nxt = xfer_snap[xfer_idx];
                            end
                            ptr_nxt = (ptr == PTR_W'(VB - 1)) ? '0 : ptr + PTR_W'(1);
                        end
                        OP_REPEAT: begin
                            instr_nxt     = OP_REPEAT;
                            addr_nxt      = '0;
                            value_nxt     = '0;
                            cmd_valid_nxt = 1'b1;
                            ptr_nxt       = '0;
                        end
                        default: begin
                            err_nxt = 1'b1;
                        end
                    endcase
                end
            end
            COLLECT: begin
                if (timeout) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b1;
                end else if (spi_rx_valid_i) begin
                    shift_nxt = shifted;
                    cnt_nxt   = cnt - CNT_W'(1);
                    if (opcode == OP_STREAM) begin
                        tx_nxt = (cnt == CNT_W'(1)) ? 8'h00 : stream_snap[stream_idx];
                    end
                    if (cnt == CNT_W'(1)) begin
                        state_nxt     = IDLE;
                        instr_nxt     = opcode;
                        cmd_valid_nxt = 1'b1;
                        case (opcode)
                            OP_WRITE: begin
                                addr_nxt  = shifted[SHW-1 -: ADDRESS_WIDTH];
                                value_nxt = shifted[VALUE_WIDTH-1:0];
                            end
                            OP_STREAM: begin
                                addr_nxt  = '0;
                                value_nxt = shifted[VALUE_WIDTH-1:0];
                            end
                            default: begin
                                addr_nxt  = shifted[ADDRESS_WIDTH-1:0];
                                value_nxt = '0;
                            end
                        endcase
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            cnt           <= '0;
            shift         <= '0;
            opcode        <= '0;
            stream_snap   <= '0;
            xfer_snap     <= '0;
            ptr           <= '0;
            instruction_o <= '0;
            address_o     <= '0;
            value_o       <= '0;
            spi_tx_byte_o <= '0;
            cmd_valid_o   <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            shift         <= shift_nxt;
            opcode        <= opcode_nxt;
            stream_snap   <= stream_snap_nxt;
            xfer_snap     <= xfer_snap_nxt;
            ptr           <= ptr_nxt;
            instruction_o <= instr_nxt;
            address_o     <= addr_nxt;
            value_o       <= value_nxt;
            spi_tx_byte_o <= tx_nxt;
            cmd_valid_o   <= cmd_valid_nxt;
            err_o         <= err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/spi_command_decoder.md
# spi_command_decoder

Parametrised successor to the byte-level SPI instruction front end. It assembles opcode/address/value frames from the SPI receive byte stream using an explicit state machine and presents each completed command as a one-cycle `cmd_valid_o` strobe. It also serves MSB-first read-back bytes for STREAM and TRANSFER with tear-free snapshots. It sits between the SPI slave byte interface and the Titan core's register/bind logic.

## Interface
- `ADDRESS_WIDTH`, 24: address field width; multiple of 8, 8..32.
- `VALUE_WIDTH`, 32: value field width; multiple of 8, 8..64.
- `TIMEOUT_CYCLES`, 1024: idle-cycle limit for a partial frame; used only with the timeout feature.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `spi_rx_valid_i` in 1: one-cycle pulse per received byte.
- `spi_rx_byte_i` in 8: received byte.
- `result_i` in VALUE_WIDTH: core result, served by TRANSFER.
- `stream_i` in VALUE_WIDTH: core stream output, served by STREAM.
- `instruction_o` out 8: opcode of the last completed command.
- `address_o` out ADDRESS_WIDTH: address field, zero when the opcode has none.
- `value_o` out VALUE_WIDTH: value field, zero when the opcode has none.
- `cmd_valid_o` out 1: one-cycle strobe; the fields above are valid while it is high.
- `err_o` out 1: one-cycle strobe on an illegal opcode or a timeout.
- `spi_tx_byte_o` out 8: next byte for the SPI slave to shift out.

## Operation
- Opcodes (TitanComms): WRITE 0x01, READ 0x02, STREAM 0x03, BIND_INTERRUPT 0x04, BIND_READ_ADDRESS 0x05, BIND_WRITE_ADDRESS 0x06, TRANSFER 0x07, REPEAT 0x08.
- Byte counts: AB = ADDRESS_WIDTH/8, VB = VALUE_WIDTH/8. Every frame starts with the opcode byte.
- Frame lengths:
  - WRITE: 1+AB+VB (address then value).
  - READ and BIND_*: 1+AB.
  - STREAM: 1+VB.
  - TRANSFER, REPEAT: 1.
- Byte order: all fields are received MSB-first.
- FSM states are IDLE and COLLECT.
- IDLE, byte 0x00: ignored, no strobe.
- IDLE, multi-byte opcode: latch the opcode, load the remaining-byte counter, go to COLLECT.
- IDLE, TRANSFER or REPEAT: complete immediately and pulse `cmd_valid_o`.
- IDLE, any other byte: pulse `err_o`, stay in IDLE.
- COLLECT: each byte shifts into an (ADDRESS_WIDTH+VALUE_WIDTH)-bit register and decrements the counter.
  - On the final byte, return to IDLE, drive the decoded fields and pulse `cmd_valid_o`.
  - Fields not carried by the opcode are driven to 0.
- STREAM transmit:
  - The opcode byte snapshots `stream_i` and loads its top byte into `spi_tx_byte_o`.
  - Value byte k (1..VB-1) loads snapshot byte VB-1-k.
  - The final byte loads 0x00.
- TRANSFER transmit:
  - A VB-position pointer starts at 0; when it is 0, `result_i` is snapshotted.
  - Each TRANSFER loads snapshot byte VB-1-pointer (MSB first), then increments the pointer.
  - The pointer wraps after VB; the next TRANSFER takes a fresh snapshot.
- REPEAT clears the pointer to 0, so the next TRANSFER re-snapshots and sends the MSB.
- The STREAM snapshot and the TRANSFER snapshot are independent registers.
- Reset values: FSM IDLE, counter 0, pointer 0, and every output 0, including `spi_tx_byte_o`.

## Timing
- `cmd_valid_o`/`err_o` go high in the cycle after the edge that samples the completing or illegal byte, for exactly one cycle.
- Output fields are registered and hold until the next completion.
- `spi_tx_byte_o` updates on the edge that samples the corresponding rx byte.
- Back-to-back frames: the opcode of the next frame may arrive in the cycle right after the final byte.
- `spi_rx_valid_i` low: no state change, apart from the timeout counter.
- Reset asserted mid-frame: the partial frame is discarded, no strobe; the first byte after reset release is treated as an opcode.

## Configuration
- `SPI_CMD_TIMEOUT_EN` defined:
  - In COLLECT, a counter runs on cycles with no `spi_rx_valid_i` and clears on each byte.
  - When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE and pulses `err_o`; no `cmd_valid_o`.
- Undefined: COLLECT waits indefinitely and no counter is synthesised.

## Test plan
- WRITE 01 12 34 56 DE AD BE EF -> `cmd_valid_o` pulses once; instruction 0x01, address 0x123456, value 0xDEADBEEF.
- READ 02 00 00 2A then immediately 05 00 01 00 -> two strobes: (0x02, 0x00002A, 0) then (0x05, 0x000100, 0).
- STREAM 03 + 4 bytes, `stream_i` = 0xA1B2C3D4 changing to 0 after the opcode -> tx sequence A1, B2, C3, D4, 00.
- `result_i` = 0x11223344: TRANSFER ×5 -> tx 11, 22, 33, 44, 11; then TRANSFER, REPEAT, TRANSFER -> tx 22, then 11.
- Byte 0xFF in IDLE -> `err_o` pulse, no `cmd_valid_o`. `rst_ni` low after 02 12 -> no strobe, all outputs 0.
- With `SPI_CMD_TIMEOUT_EN`, TIMEOUT_CYCLES = 16: send 01 12 then idle 16 cycles -> `err_o` pulse; then READ 02 00 00 01 decodes normally.
